// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between two requesters.
// One-entry issue register feeds the ALU; results land in per-requester response registers.
module alu_share_arb #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             a_req_valid,
   output logic             a_req_ready,
   input  logic [5:0]       a_op,
   input  logic [31:0]      a_rv1,
   input  logic [31:0]      a_rv2,
   output logic             a_rsp_valid,
   input  logic             a_rsp_ready,
   output logic [31:0]      a_rsp_data,
   output logic             a_rsp_err,

   input  logic             b_req_valid,
   output logic             b_req_ready,
   input  logic [5:0]       b_op,
   input  logic [31:0]      b_rv1,
   input  logic [31:0]      b_rv2,
   output logic             b_rsp_valid,
   input  logic             b_rsp_ready,
   output logic [31:0]      b_rsp_data,
   output logic             b_rsp_err,

   output logic [5:0]       alu_op,
   output logic [31:0]      alu_rv1,
   output logic [31:0]      alu_rv2,
   input  logic [31:0]      alu_rvout,

   output logic [CNT_W-1:0] issue_cnt,
   output logic             busy
);

   localparam logic [5:0] OpMax = 6'h12;

   // Issue register; owner 0 = A, 1 = B
   logic              iss_vld_q, iss_vld_d;
   logic              iss_own_q, iss_own_d;
   logic [5:0]        iss_op_q, iss_op_d;
   logic [31:0]       iss_rv1_q, iss_rv1_d;
   logic [31:0]       iss_rv2_q, iss_rv2_d;

   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              a_rsp_vld_q, a_rsp_vld_d;
   logic [31:0]       a_rsp_data_q, a_rsp_data_d;
   logic              a_rsp_err_q, a_rsp_err_d;
   logic              b_rsp_vld_q, b_rsp_vld_d;
   logic [31:0]       b_rsp_data_q, b_rsp_data_d;
   logic              b_rsp_err_q, b_rsp_err_d;

   logic              a_inflight, b_inflight;
   logic              a_elig, b_elig;
   logic              a_cand, b_cand;
   logic              gnt_a, gnt_b, gnt;
   logic              res_err;
   logic [31:0]       res_data;

   // Eligibility never looks at the requester's own req_valid
   always_comb begin
      a_inflight = iss_vld_q & ~iss_own_q;
      b_inflight = iss_vld_q & iss_own_q;
      a_elig     = ~a_inflight & (~a_rsp_vld_q | a_rsp_ready);
      b_elig     = ~b_inflight & (~b_rsp_vld_q | b_rsp_ready);
      a_cand     = a_elig & a_req_valid;
      b_cand     = b_elig & b_req_valid;
      // last_q = 1 means B was granted last, so A wins a tie
      gnt_a      = a_cand & (~b_cand | last_q);
      gnt_b      = b_cand & (~a_cand | ~last_q);
      gnt        = gnt_a | gnt_b;
   end

   always_comb begin
      res_err  = (iss_op_q > OpMax);
      res_data = res_err ? 32'd0 : alu_rvout;
   end

   always_comb begin
      iss_vld_d = 1'b0;
      iss_own_d = iss_own_q;
      iss_op_d  = iss_op_q;
      iss_rv1_d = iss_rv1_q;
      iss_rv2_d = iss_rv2_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      if (gnt) begin
         iss_vld_d = 1'b1;
         iss_own_d = gnt_b;
         iss_op_d  = gnt_b ? b_op  : a_op;
         iss_rv1_d = gnt_b ? b_rv1 : a_rv1;
         iss_rv2_d = gnt_b ? b_rv2 : a_rv2;
         last_d    = gnt_b;
         cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Completion and handshake on the same requester are mutually exclusive by eligibility
   always_comb begin
      a_rsp_vld_d  = a_rsp_vld_q;
      a_rsp_data_d = a_rsp_data_q;
      a_rsp_err_d  = a_rsp_err_q;
      if (a_inflight) begin
         a_rsp_vld_d  = 1'b1;
         a_rsp_data_d = res_data;
         a_rsp_err_d  = res_err;
      end else if (a_rsp_vld_q && a_rsp_ready) begin
         a_rsp_vld_d  = 1'b0;
      end
   end

   always_comb begin
      b_rsp_vld_d  = b_rsp_vld_q;
      b_rsp_data_d = b_rsp_data_q;
      b_rsp_err_d  = b_rsp_err_q;
      if (b_inflight) begin
         b_rsp_vld_d  = 1'b1;
         b_rsp_data_d = res_data;
         b_rsp_err_d  = res_err;
      end else if (b_rsp_vld_q && b_rsp_ready) begin
         b_rsp_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iss_vld_q    <= 1'b0;
         iss_own_q    <= 1'b0;
         iss_op_q     <= 6'd0;
         iss_rv1_q    <= 32'd0;
         iss_rv2_q    <= 32'd0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         a_rsp_vld_q  <= 1'b0;
         a_rsp_data_q <= 32'd0;
         a_rsp_err_q  <= 1'b0;
         b_rsp_vld_q  <= 1'b0;
         b_rsp_data_q <= 32'd0;
         b_rsp_err_q  <= 1'b0;
      end else begin
         iss_vld_q    <= iss_vld_d;
         iss_own_q    <= iss_own_d;
         iss_op_q     <= iss_op_d;
         iss_rv1_q    <= iss_rv1_d;
         iss_rv2_q    <= iss_rv2_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         a_rsp_vld_q  <= a_rsp_vld_d;
         a_rsp_data_q <= a_rsp_data_d;
         a_rsp_err_q  <= a_rsp_err_d;
         b_rsp_vld_q  <= b_rsp_vld_d;
         b_rsp_data_q <= b_rsp_data_d;
         b_rsp_err_q  <= b_rsp_err_d;
      end
   end

   // Ready is combinational, so gate it to keep every output low during reset
   always_comb begin
      a_req_ready = gnt_a & reset;
      b_req_ready = gnt_b & reset;
      a_rsp_valid = a_rsp_vld_q;
      a_rsp_data  = a_rsp_data_q;
      a_rsp_err   = a_rsp_err_q;
      b_rsp_valid = b_rsp_vld_q;
      b_rsp_data  = b_rsp_data_q;
      b_rsp_err   = b_rsp_err_q;
      alu_op      = iss_vld_q ? iss_op_q  : 6'd0;
      alu_rv1     = iss_vld_q ? iss_rv1_q : 32'd0;
      alu_rv2     = iss_vld_q ? iss_rv2_q : 32'd0;
      issue_cnt   = cnt_q;
      busy        = iss_vld_q;
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table, hand sequences, and randomized traffic
// checked against a timestamp/queue style reference of the arbitration rules.
module tb_alu_share_arb;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [5:0]    a_op;
   logic [31:0]   a_rv1, a_rv2, a_rsp_data;
   logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [5:0]    b_op;
   logic [31:0]   b_rv1, b_rv2, b_rsp_data;
   logic [5:0]    alu_op;
   logic [31:0]   alu_rv1, alu_rv2, alu_rvout;
   logic [CW-1:0] issue_cnt;
   logic          busy;

   int checks = 0;
   int failures = 0;

   alu_share_arb #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_op(a_op),
      .a_rv1(a_rv1), .a_rv2(a_rv2), .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
      .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_op(b_op),
      .b_rv1(b_rv1), .b_rv2(b_rv2), .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
      .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
      .alu_op(alu_op), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2), .alu_rvout(alu_rvout),
      .issue_cnt(issue_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: 0x00-0x08 immediate forms, 0x09-0x12 register forms
   function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
      logic [4:0] sh;
      sh = y[4:0];
      case (op)
         6'h00, 6'h09: alu_f = x + y;
         6'h0A:        alu_f = x - y;
         6'h01, 6'h0C: alu_f = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         6'h02, 6'h0D: alu_f = (x < y) ? 32'd1 : 32'd0;
         6'h03, 6'h0E: alu_f = x ^ y;
         6'h04, 6'h11: alu_f = x | y;
         6'h05, 6'h12: alu_f = x & y;
         6'h06, 6'h0B: alu_f = x << sh;
         6'h07, 6'h0F: alu_f = x >> sh;
         6'h08, 6'h10: alu_f = $signed(x) >>> sh;
         default:      alu_f = 32'hDEADBEEF;
      endcase
   endfunction

   always_comb alu_rvout = alu_f(alu_op, alu_rv1, alu_rv2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: per-requester outstanding flag plus acceptance timestamp
   bit          m_out[2];
   int          m_acc[2];
   logic [31:0] m_data[2];
   logic        m_err[2];
   bit          m_last;     // 1: B granted last
   int          m_cnt;
   int          m_cyc;
   int          m_gcyc;
   logic [5:0]  m_op;
   logic [31:0] m_r1, m_r2;

   task automatic model_reset();
      m_out[0] = 0; m_out[1] = 0;
      m_acc[0] = 0; m_acc[1] = 0;
      m_last = 1; m_cnt = 0; m_cyc = 0; m_gcyc = -1;
      m_op = 6'd0; m_r1 = 32'd0; m_r2 = 32'd0;
   endtask

   // One cycle: compare outputs mid-cycle, advance model across the rising edge
   task automatic step();
      bit vis[2], cons[2], elig[2], rq[2], g[2];
      bit bsy;
      logic [5:0]  op[2];
      logic [31:0] r1[2], r2[2];
      #1;
      op[0] = a_op; r1[0] = a_rv1; r2[0] = a_rv2;
      op[1] = b_op; r1[1] = b_rv1; r2[1] = b_rv2;
      for (int x = 0; x < 2; x++) vis[x] = m_out[x] && (m_cyc > m_acc[x]);
      cons[0] = vis[0] && a_rsp_ready;
      cons[1] = vis[1] && b_rsp_ready;
      for (int x = 0; x < 2; x++) elig[x] = !m_out[x] || cons[x];
      rq[0] = elig[0] && a_req_valid;
      rq[1] = elig[1] && b_req_valid;
      g[0] = rq[0] && (!rq[1] || m_last);
      g[1] = rq[1] && (!rq[0] || !m_last);
      bsy = (m_gcyc == m_cyc);
      chk("a_req_ready", 32'(a_req_ready), 32'(g[0]));
      chk("b_req_ready", 32'(b_req_ready), 32'(g[1]));
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(vis[0]));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(vis[1]));
      if (vis[0]) begin
         chk("a_rsp_data", a_rsp_data, m_data[0]);
         chk("a_rsp_err", 32'(a_rsp_err), 32'(m_err[0]));
      end
      if (vis[1]) begin
         chk("b_rsp_data", b_rsp_data, m_data[1]);
         chk("b_rsp_err", 32'(b_rsp_err), 32'(m_err[1]));
      end
      chk("busy", 32'(busy), 32'(bsy));
      chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt % (1 << CW)));
      chk("alu_op", 32'(alu_op), bsy ? 32'(m_op) : 32'd0);
      chk("alu_rv1", alu_rv1, bsy ? m_r1 : 32'd0);
      chk("alu_rv2", alu_rv2, bsy ? m_r2 : 32'd0);
      @(posedge clk);
      for (int x = 0; x < 2; x++) begin
         if (cons[x]) m_out[x] = 0;
         if (g[x]) begin
            m_out[x]  = 1;
            m_acc[x]  = m_cyc + 1;
            m_err[x]  = (op[x] > 6'h12);
            m_data[x] = m_err[x] ? 32'd0 : alu_f(op[x], r1[x], r2[x]);
            m_last    = (x == 1);
            m_cnt++;
            m_gcyc    = m_cyc + 1;
            m_op = op[x]; m_r1 = r1[x]; m_r2 = r2[x];
         end
      end
      m_cyc++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      a_req_valid = 0; a_op = 6'd0; a_rv1 = 32'd0; a_rv2 = 32'd0; a_rsp_ready = 0;
      b_req_valid = 0; b_op = 6'd0; b_rv1 = 32'd0; b_rv2 = 32'd0; b_rsp_ready = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1;
      model_reset();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_req_ready"}, 32'(a_req_ready), 32'd0);
      chk({tag, "_b_req_ready"}, 32'(b_req_ready), 32'd0);
      chk({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
      chk({tag, "_a_rsp_data"}, a_rsp_data, 32'd0);
      chk({tag, "_a_rsp_err"}, 32'(a_rsp_err), 32'd0);
      chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'd0);
      chk({tag, "_b_rsp_data"}, b_rsp_data, 32'd0);
      chk({tag, "_b_rsp_err"}, 32'(b_rsp_err), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_alu_rv1"}, alu_rv1, 32'd0);
      chk({tag, "_alu_rv2"}, alu_rv2, 32'd0);
      chk({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   function automatic logic [5:0] rnd_op();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0)      rnd_op = 6'h3F;
      else if (r == 1) rnd_op = 6'($urandom_range(8'h13, 8'h3E));
      else             rnd_op = 6'($urandom_range(0, 8'h12));
   endfunction

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] dat;
      logic        err;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{"sub",     6'h0A, 32'd5,          32'd7,  32'hFFFFFFFE, 1'b0};
      tbl[1] = '{"sra",     6'h10, 32'h80000000,   32'd4,  32'hF8000000, 1'b0};
      tbl[2] = '{"slt",     6'h0C, 32'hFFFFFFFF,   32'd1,  32'd1,        1'b0};
      tbl[3] = '{"sltu",    6'h0D, 32'hFFFFFFFF,   32'd1,  32'd0,        1'b0};
      tbl[4] = '{"illegal", 6'h3F, 32'h12345678,   32'd9,  32'd0,        1'b1};
      tbl[5] = '{"add",     6'h09, 32'd1,          32'd1,  32'd2,        1'b0};
      tbl[6] = '{"xor",     6'h0E, 32'hF0,         32'h0F, 32'hFF,       1'b0};

      reset = 0;
      idle_inputs();
      #2;
      check_zero("por");
      do_reset();

      // Directed single operations from A
      a_rsp_ready = 1;
      for (int i = 0; i < 7; i++) begin
         a_req_valid = 1; a_op = tbl[i].op; a_rv1 = tbl[i].r1; a_rv2 = tbl[i].r2;
         #1 chk({tbl[i].name, "_accept"}, 32'(a_req_ready), 32'd1);
         step();
         a_req_valid = 0;
         step();
         #1;
         chk({tbl[i].name, "_valid"}, 32'(a_rsp_valid), 32'd1);
         chk({tbl[i].name, "_data"}, a_rsp_data, tbl[i].dat);
         chk({tbl[i].name, "_err"}, 32'(a_rsp_err), 32'(tbl[i].err));
         chk({tbl[i].name, "_cnt"}, 32'(issue_cnt), 32'(i + 1));
         step();
      end

      // Reset in the middle of an A operation
      do_reset();
      a_rsp_ready = 1;
      a_req_valid = 1; a_op = 6'h09; a_rv1 = 32'd3; a_rv2 = 32'd4;
      step();
      b_req_valid = 1; b_op = 6'h0E;
      #2 reset = 0;
      #1 check_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      model_reset();
      a_req_valid = 0; b_req_valid = 0;
      step();
      step();
      #1 chk("rst_no_rsp", 32'(a_rsp_valid), 32'd0);
      a_req_valid = 1; b_req_valid = 1;
      #1;
      chk("rst_first_a", 32'(a_req_ready), 32'd1);
      chk("rst_first_b", 32'(b_req_ready), 32'd0);
      step();

      // Contention: alternating grants, counter wraps after the 16th grant
      do_reset();
      a_req_valid = 1; a_op = 6'h09; a_rv1 = 32'd1;  a_rv2 = 32'd1;  a_rsp_ready = 1;
      b_req_valid = 1; b_op = 6'h0E; b_rv1 = 32'hF0; b_rv2 = 32'h0F; b_rsp_ready = 1;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("cont_grant_a", 32'(a_req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_grant_b", 32'(b_req_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         step();
         #1 chk("cont_cnt", 32'(issue_cnt), 32'((k + 1) % 16));
      end
      chk("wrap_cnt", 32'(issue_cnt), 32'd0);

      // Backpressure on B's response channel
      do_reset();
      a_req_valid = 1; a_op = 6'h09; a_rv1 = 32'd1;  a_rv2 = 32'd1;  a_rsp_ready = 1;
      b_req_valid = 1; b_op = 6'h0E; b_rv1 = 32'hF0; b_rv2 = 32'h0F; b_rsp_ready = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("bp_a_rate", 32'(a_req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k >= 2) chk("bp_b_blocked", 32'(b_req_ready), 32'd0);
         if (k >= 3) begin
            chk("bp_b_hold_valid", 32'(b_rsp_valid), 32'd1);
            chk("bp_b_hold_data", b_rsp_data, 32'hFF);
         end
         step();
      end
      b_rsp_ready = 1;
      #1 chk("bp_b_release", 32'(b_req_ready), 32'd1);
      step();
      step();

      // Randomized traffic against the reference
      do_reset();
      for (int n = 0; n < 600; n++) begin
         a_req_valid = ($urandom_range(0, 3) != 0);
         a_op = rnd_op(); a_rv1 = $urandom(); a_rv2 = $urandom();
         a_rsp_ready = ($urandom_range(0, 2) != 0);
         b_req_valid = ($urandom_range(0, 3) != 0);
         b_op = rnd_op(); b_rv1 = $urandom(); b_rv2 = $urandom();
         b_rsp_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and issue sequencer that shares a single 32-bit integer ALU between two requesters, e.g. the execute stage and a debug/test port. Each requester has a valid/ready request channel and a valid/ready response channel. Requests are granted round-robin into a one-entry issue register that drives the shared ALU. The result is captured into the granted requester's response register one cycle later. Throughput is one operation per cycle with at most one outstanding operation per requester.

## Interface
Parameters:
- CNT_W, 16, width of the wrapping issue counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- a_req_valid  in  1  requester A has an operation
- a_req_ready  out  1  request from A accepted this cycle
- a_op  in  6  ALU opcode, 0x00–0x12 legal (ADDI..AND encoding)
- a_rv1, a_rv2  in  32  operands
- a_rsp_valid  out  1  result for A available
- a_rsp_ready  in  1  A consumes result
- a_rsp_data  out  32  result
- a_rsp_err  out  1  opcode was > 0x12 (data is 0)
- b_* : identical set for requester B
- alu_op  out  6  to shared ALU
- alu_rv1, alu_rv2  out  32  to shared ALU
- alu_rvout  in  32  combinational ALU result
- issue_cnt  out  CNT_W  number of accepted requests, wraps at 2^CNT_W
- busy  out  1  issue register valid

## Operation
- Eligibility: requester X is eligible when it has no operation in flight in the issue register and its response register is empty. A completed, not-yet-consumed response that is consumed this cycle (rsp_valid & rsp_ready) makes X eligible in the same cycle.
- Arbitration:
  - Only A eligible & valid -> grant A. Only B eligible & valid -> grant B.
  - Both eligible & valid -> grant the requester not granted last; `last` resets to B, so A wins first.
  - At most one grant per cycle.
- x_req_ready = eligible_x & grant_x. It may depend combinationally on both req_valids; it must not depend on x_req_valid for X's own eligibility.
- On grant: the issue register loads {owner, op, rv1, rv2} and sets valid; `last` <= owner; issue_cnt increments.
- Issue register valid drives alu_op/rv1/rv2. When it is not valid, it drives alu_op = 0 and operands = 0.
- Every cycle the issue register is valid, the owner's response register loads alu_rvout:
  - rsp_err = (op > 0x12)
  - rsp_valid <= 1
  - the issue register clears unless a new grant loads it in the same cycle.
- A response is held stable until rsp_ready. Handshake: rsp_valid & rsp_ready clears rsp_valid.
- Simultaneous issue completion to X and X's rsp handshake cannot occur, because eligibility forbids it.
- No reordering: each requester sees responses in request order, trivially, since one is outstanding per requester.
- Reset (asynchronous, any cycle, including mid-operation):
  - issue register invalid
  - both rsp_valid = 0, rsp_data = 0, rsp_err = 0
  - issue_cnt = 0, last = B
  - in-flight operation is discarded, with no response produced
  - all outputs 0 while reset is low.

## Timing
- Request accepted at edge N (valid & ready high in cycle N-1→N window).
- alu_* outputs show the op during cycle N→N+1.
- x_rsp_valid rises after edge N+1. Latency is 2 edges from acceptance to response visible; 1 cycle of ALU occupancy.
- Back-to-back: with both requesters consuming responses immediately (rsp_ready tied 1), grants alternate A,B,A,B at one per cycle. A single requester alone achieves one request every 2 cycles, because its next request waits for its response to be consumed.
- issue_cnt and busy are registered; they update at the granting edge.
- Counter wrap: 2^CNT_W−1 + 1 -> 0, with no flag.

## Test plan
- Reset: assert reset low mid-operation with a_req in flight. Required: all outputs 0 immediately (asynchronous), no a_rsp_valid after release, and the first grant after release goes to A.
- Single op: A sends op 0x0A (SUB), rv1 = 5, rv2 = 7, rsp_ready = 1. Required: a_rsp_valid 2 edges after acceptance, a_rsp_data = 0xFFFFFFFE, a_rsp_err = 0.
- Contention: A and B valid every cycle, both rsp_ready = 1, A ADD 1+1, B XOR 0xF0^0x0F. Required: alternating grants A,B,A,…; A data = 2, B data = 0xFF; issue_cnt increments each cycle.
- Backpressure: b_rsp_ready = 0 after B's first response. Required: b_req_ready stays 0, b_rsp_data is held stable, and A continues at its full rate. Raising b_rsp_ready re-enables B's grant in the same cycle.
- Illegal op: A sends op 0x3F. Required: a_rsp_err = 1, a_rsp_data = 0, issue_cnt increments.
- Signed/shift checks via the arbiter:
  - SRA 0x80000000 >> 4 -> 0xF8000000
  - SLT −1 < 1 -> 1
  - SLTU 0xFFFFFFFF < 1 -> 0
  - issue_cnt with CNT_W = 4 wraps 15 -> 0 after the 16th grant.
